// File: rtl/card_counter_pkg.sv
// ---------------------------------------------------------------------------
// card_counter_pkg
// Shared constants, types and helpers for the card_counter block.
//   - RANK_ACE / RANK_KING : legal rank range (1 = ace, 11..13 = J/Q/K)
//   - CARDS_PER_DECK       : cards in one standard deck
//   - DIV_W / DIV_ITERS    : true-count divider width and iteration count
//   - tc_state_t           : true-count FSM states
//   - hilo_weight()        : Hi-Lo weight of a rank (+1 / 0 / -1)
//   - rank_valid()         : rank lies in 1..13
// ---------------------------------------------------------------------------
package card_counter_pkg;

    localparam logic [3:0] RANK_ACE       = 4'd1;
    localparam logic [3:0] RANK_KING      = 4'd13;
    localparam int         CARDS_PER_DECK = 52;

    localparam int DIV_W     = 24;
    localparam int DIV_ITERS = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } tc_state_t;

    function automatic logic rank_valid(input logic [3:0] rank);
        return (rank >= RANK_ACE) && (rank <= RANK_KING);
    endfunction

    // Hi-Lo: low cards (2..6) count up, neutral (7..9) zero, high (10..K, A) down.
    function automatic logic signed [15:0] hilo_weight(input logic [3:0] rank);
        if (rank >= 4'd2 && rank <= 4'd6) begin
            return 16'sd1;
        end else if (rank == RANK_ACE || (rank >= 4'd10 && rank <= RANK_KING)) begin
            return -16'sd1;
        end else begin
            return 16'sd0;
        end
    endfunction

endpackage

// File: rtl/card_counter_if.sv
// ---------------------------------------------------------------------------
// card_counter_if
// Command and status bundle of card_counter.
//   Commands (master -> slave): new_shoe, deck_add, back, card_valid,
//                               card_rank[3:0], query_rank[3:0]
//   Status   (slave -> master): deck[7:0], total[15:0], remain[15:0],
//                               running (s16), query_left[7:0], err,
//                               tc (s16), tc_valid
// ---------------------------------------------------------------------------
interface card_counter_if;

    logic               new_shoe;
    logic               deck_add;
    logic               back;
    logic               card_valid;
    logic [3:0]         card_rank;
    logic [3:0]         query_rank;

    logic [7:0]         deck;
    logic [15:0]        total;
    logic [15:0]        remain;
    logic signed [15:0] running;
    logic [7:0]         query_left;
    logic               err;
    logic signed [15:0] tc;
    logic               tc_valid;

    modport master (
        output new_shoe, deck_add, back, card_valid, card_rank, query_rank,
        input  deck, total, remain, running, query_left, err, tc, tc_valid
    );

    modport slave (
        input  new_shoe, deck_add, back, card_valid, card_rank, query_rank,
        output deck, total, remain, running, query_left, err, tc, tc_valid
    );

endinterface

// File: rtl/card_counter_div.sv
// ---------------------------------------------------------------------------
// card_counter_div
// Unsigned restoring divider, one quotient bit per clock, DIV_ITERS bits.
// Only compiled when CARD_COUNTER_TC_EN is defined (it has no other user).
//   clk, rst (async, active-low)
//   start    : load dividend/divisor and begin; also restarts a running job
//   dividend : DIV_W-bit magnitude
//   divisor  : 16-bit magnitude, must be non-zero
//   busy     : iterations in progress
//   done     : high during the cycle whose closing edge retires the last
//              iteration; quotient is final from that edge on
//   quotient : DIV_W-bit result (partial while busy)
// ---------------------------------------------------------------------------
`ifdef CARD_COUNTER_TC_EN
module card_counter_div
    import card_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [15:0]      divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int ITER_W = $clog2(DIV_ITERS);

    logic [15:0]       rem_reg;
    logic [DIV_W-1:0]  quot_reg;
    logic [15:0]       dsr_reg;
    logic [ITER_W-1:0] iter_reg;
    logic              busy_reg;

    // Partial remainder shifted left with the next dividend bit brought in.
    // The remainder is always below the divisor, so 17 bits are enough.
    logic [16:0]       rem_shift;
    logic              fits;
    logic [15:0]       rem_trial;

    assign rem_shift = {rem_reg, quot_reg[DIV_W-1]};
    assign fits      = rem_shift >= {1'b0, dsr_reg};
    // Only used when fits, where the true difference is below the divisor.
    assign rem_trial = rem_shift[15:0] - dsr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_reg  <= '0;
            quot_reg <= '0;
            dsr_reg  <= '0;
            iter_reg <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= '0;
            quot_reg <= dividend;
            dsr_reg  <= divisor;
            iter_reg <= ITER_W'(DIV_ITERS - 1);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            rem_reg  <= fits ? rem_trial : rem_shift[15:0];
            quot_reg <= {quot_reg[DIV_W-2:0], fits};
            iter_reg <= iter_reg - ITER_W'(1);
            if (iter_reg == '0) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = busy_reg && (iter_reg == '0);
    assign quotient = quot_reg;

endmodule
`endif

// File: rtl/card_counter.sv
// ---------------------------------------------------------------------------
// card_counter
// Blackjack shoe tracker: deck count, cards dealt, per-rank counts, Hi-Lo
// running count with a bounded undo history, and an optional true count.
//
// Parameters
//   NDECK_MAX  : maximum decks in the shoe (1..255)
//   HIST_DEPTH : undo history entries (power of two, >= 2)
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset
//   bus        : card_counter_if.slave (commands in, status out)
// Commands are taken one per cycle, priority new_shoe > deck_add > back >
// card_valid; a rejected command pulses err for one cycle.
//
// Build option: define CARD_COUNTER_TC_EN to build the true-count FSM and
// divider (tc = trunc(running*52/remain)); without it tc and tc_valid are 0.
// ---------------------------------------------------------------------------
module card_counter
    import card_counter_pkg::*;
#(
    parameter int NDECK_MAX  = 8,
    parameter int HIST_DEPTH = 8
)
(
    input  logic           clk,
    input  logic           rst,
    card_counter_if.slave  bus
);

    localparam int         CNT_W      = $clog2(4 * NDECK_MAX + 1);
    localparam int         PTR_W      = $clog2(HIST_DEPTH);
    localparam logic [7:0] DECK_LIMIT = 8'(NDECK_MAX);

    // ---------------------------------------------------------------- state
    logic [7:0]         deck_reg;
    logic [15:0]        total_reg;
    logic signed [15:0] running_reg;
    logic               err_reg;

    logic [3:0]         hist_mem [HIST_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W:0]     hist_cnt_reg;

    logic [CNT_W-1:0]   rank_cnt  [16];
    logic [7:0]         rank_left [16];

    // ---------------------------------------------------------- derived
    logic [9:0]         rank_quota;   // 4 * deck
    logic [15:0]        shoe_size;    // 52 * deck
    logic [15:0]        remain;

    assign rank_quota = {deck_reg, 2'b00};
    assign shoe_size  = 16'(deck_reg) * 16'(CARDS_PER_DECK);
    assign remain     = shoe_size - total_reg;

    // --------------------------------------------------- command decode
    logic             do_new, do_deck, do_back, do_card;
    logic             deck_ok, back_ok, card_ok, hist_empty, cmd_err;
    logic [PTR_W-1:0] pop_ptr;
    logic [3:0]       pop_rank;
    logic [CNT_W-1:0] card_cnt;

    assign do_new  = bus.new_shoe;
    assign do_deck = !bus.new_shoe && bus.deck_add;
    assign do_back = !bus.new_shoe && !bus.deck_add && bus.back;
    assign do_card = !bus.new_shoe && !bus.deck_add && !bus.back && bus.card_valid;

    assign hist_empty = (hist_cnt_reg == '0);
    assign pop_ptr    = wr_ptr_reg - PTR_W'(1);
    assign pop_rank   = hist_mem[pop_ptr];
    assign card_cnt   = rank_cnt[bus.card_rank];

    assign deck_ok = do_deck && (total_reg == '0) && (deck_reg < DECK_LIMIT);
    assign back_ok = do_back && !hist_empty;
    assign card_ok = do_card && rank_valid(bus.card_rank)
                     && (10'(card_cnt) < rank_quota)
                     && (total_reg < shoe_size);

    // new_shoe is always accepted, so it never contributes to err.
    assign cmd_err = (do_deck && !deck_ok)
                   || (do_back && hist_empty)
                   || (do_card && !card_ok);

    // ------------------------------------------------ totals and history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deck_reg     <= '0;
            total_reg    <= '0;
            running_reg  <= '0;
            err_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            hist_cnt_reg <= '0;
        end else begin
            err_reg <= cmd_err;
            if (do_new) begin
                total_reg    <= '0;
                running_reg  <= '0;
                wr_ptr_reg   <= '0;
                hist_cnt_reg <= '0;
            end else if (deck_ok) begin
                deck_reg <= deck_reg + 8'd1;
            end else if (back_ok) begin
                total_reg    <= total_reg - 16'd1;
                running_reg  <= running_reg - hilo_weight(pop_rank);
                wr_ptr_reg   <= pop_ptr;
                hist_cnt_reg <= hist_cnt_reg - (PTR_W+1)'(1);
            end else if (card_ok) begin
                total_reg   <= total_reg + 16'd1;
                running_reg <= running_reg + hilo_weight(bus.card_rank);
                wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
                // When full the pointer wraps onto the oldest entry; the
                // occupancy just stays saturated.
                if (hist_cnt_reg != (PTR_W+1)'(HIST_DEPTH)) begin
                    hist_cnt_reg <= hist_cnt_reg + (PTR_W+1)'(1);
                end
            end
        end
    end

    // History contents need no reset: occupancy decides what is readable.
    always_ff @(posedge clk) begin
        if (card_ok) begin
            hist_mem[wr_ptr_reg] <= bus.card_rank;
        end
    end

    // ------------------------------------------------- per-rank counters
    // Index 0 and 14..15 are unused ranks, tied to zero so the rank-indexed
    // lookups need no range guard.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rank
        if (gi >= 1 && gi <= 13) begin : g_live
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (do_new) begin
                    cnt_reg <= '0;
                end else if (back_ok && pop_rank == 4'(gi)) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end else if (card_ok && bus.card_rank == 4'(gi)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign rank_cnt[gi]  = cnt_reg;
            assign rank_left[gi] = 8'(rank_quota - 10'(cnt_reg));
        end else begin : g_none
            assign rank_cnt[gi]  = '0;
            assign rank_left[gi] = '0;
        end
    end

    // --------------------------------------------------------- outputs
    assign bus.deck       = deck_reg;
    assign bus.total      = total_reg;
    assign bus.remain     = remain;
    assign bus.running    = running_reg;
    assign bus.query_left = rank_left[bus.query_rank];
    assign bus.err        = err_reg;

`ifdef CARD_COUNTER_TC_EN
    // ------------------------------------------------------ true count
    tc_state_t          state_reg, state_next;
    logic               tc_trigger;
    logic               div_start, div_busy, div_done;
    logic [DIV_W-1:0]   div_quot;
    logic [DIV_W-1:0]   dividend_mag;
    logic [15:0]        run_mag;
    logic [15:0]        tc_mag;
    logic               neg_reg, zero_reg, tc_valid_reg;
    logic signed [15:0] tc_reg;

    // Anything that moves running or remain invalidates the true count.
    assign tc_trigger = do_new || card_ok || back_ok;

    // Sign-magnitude: divide |running|*52 by remain, re-apply the sign.
    assign run_mag      = running_reg[15] ? 16'(-running_reg) : 16'(running_reg);
    assign dividend_mag = DIV_W'(run_mag) * DIV_W'(CARDS_PER_DECK);
    // Large counts against a nearly empty shoe can exceed 16 bits; clamp.
    assign tc_mag       = (div_quot > DIV_W'(32767)) ? 16'd32767 : div_quot[15:0];

    always_comb begin
        state_next = state_reg;
        div_start  = 1'b0;
        if (tc_trigger) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                LOAD: begin
                    if (remain == '0) begin
                        state_next = DONE;
                    end else begin
                        div_start  = 1'b1;
                        state_next = DIV;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state_next = DONE;
                    end else if (!div_busy) begin
                        state_next = LOAD;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            tc_reg       <= '0;
            tc_valid_reg <= 1'b0;
            neg_reg      <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == LOAD && !tc_trigger) begin
                neg_reg  <= running_reg[15];
                zero_reg <= (remain == '0);
            end
            if (tc_trigger) begin
                tc_valid_reg <= 1'b0;
            end else if (state_reg == DONE) begin
                tc_valid_reg <= 1'b1;
                tc_reg       <= zero_reg ? 16'sd0
                              : (neg_reg ? $signed(-tc_mag) : $signed(tc_mag));
            end
        end
    end

    card_counter_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend_mag),
        .divisor  (remain),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign bus.tc       = tc_reg;
    assign bus.tc_valid = tc_valid_reg;
`else
    assign bus.tc       = '0;
    assign bus.tc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_card_counter.sv
// ---------------------------------------------------------------------------
// tb_card_counter
// Directed bench for card_counter: a vector table for single-cycle command
// behaviour, then hand-written sequences for multi-cycle corners (rank
// exhaustion, deck limit, undo depth, true-count latency and restart,
// empty shoe, reset during a division).
// ---------------------------------------------------------------------------
module tb_card_counter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    card_counter_if bus();

    card_counter #(
        .NDECK_MAX  (8),
        .HIST_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

`ifdef CARD_COUNTER_TC_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ns, da, bk, cv;
        logic [3:0] rank, qrank;
        int         deck, total, running, qleft;
        logic       err;
    } vec_t;

    vec_t vecs [19];

    logic [3:0] undo_cards [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                    4'd10, 4'd11, 4'd1, 4'd7, 4'd2};

    function automatic vec_t mkv(input logic ns, da, bk, cv,
                                 input logic [3:0] rank, qrank,
                                 input int deck, total, running, qleft,
                                 input logic err);
        vec_t v;
        v.ns = ns; v.da = da; v.bk = bk; v.cv = cv;
        v.rank = rank; v.qrank = qrank;
        v.deck = deck; v.total = total; v.running = running; v.qleft = qleft;
        v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input integer act, input integer exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic check_state(input string tag, input int d, input int t,
                               input int r, input int ql, input int e);
        check({tag, " deck"},       bus.deck,       d);
        check({tag, " total"},      bus.total,      t);
        check({tag, " remain"},     bus.remain,     52 * d - t);
        check({tag, " running"},    bus.running,    r);
        check({tag, " query_left"}, bus.query_left, ql);
        check({tag, " err"},        bus.err,        e);
    endtask

    task automatic clear_cmd();
        bus.new_shoe   = 1'b0;
        bus.deck_add   = 1'b0;
        bus.back       = 1'b0;
        bus.card_valid = 1'b0;
        bus.card_rank  = 4'd0;
    endtask

    task automatic step(input logic ns, da, bk, cv, input logic [3:0] rank);
        bus.new_shoe   = ns;
        bus.deck_add   = da;
        bus.back       = bk;
        bus.card_valid = cv;
        bus.card_rank  = rank;
        @(posedge clk);
        #1;
        clear_cmd();
    endtask

    task automatic card(input logic [3:0] r);
        step(1'b0, 1'b0, 1'b0, 1'b1, r);
    endtask

    task automatic do_reset();
        clear_cmd();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Edges until tc_valid rises (0 = not within the bound), then tc.
    task automatic measure_tc(input string name, input int exp_lat, input int exp_tc);
        int lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus.tc_valid === 1'b1) lat = n;
        end
        check({name, " tc latency"}, lat, exp_lat);
        check({name, " tc"}, bus.tc, exp_tc);
    endtask

    task automatic watch_no_valid(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.tc_valid === 1'b1) seen = 1;
        end
        check(name, seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ns da bk cv rank qrank | deck total running qleft err
        vecs[0]  = mkv(0,1,0,0, 4'd0,  4'd1,  1,0, 0, 4,0);
        vecs[1]  = mkv(0,1,0,0, 4'd0,  4'd1,  2,0, 0, 8,0);
        vecs[2]  = mkv(0,0,0,1, 4'd5,  4'd5,  2,1, 1, 7,0);
        vecs[3]  = mkv(0,0,0,1, 4'd0,  4'd5,  2,1, 1, 7,1);
        vecs[4]  = mkv(0,0,0,1, 4'd14, 4'd5,  2,1, 1, 7,1);
        vecs[5]  = mkv(0,1,0,0, 4'd0,  4'd5,  2,1, 1, 7,1);
        vecs[6]  = mkv(0,0,0,1, 4'd10, 4'd10, 2,2, 0, 7,0);
        vecs[7]  = mkv(0,0,0,1, 4'd1,  4'd1,  2,3,-1, 7,0);
        vecs[8]  = mkv(0,0,0,1, 4'd8,  4'd8,  2,4,-1, 7,0);
        vecs[9]  = mkv(0,0,1,0, 4'd0,  4'd8,  2,3,-1, 8,0);
        vecs[10] = mkv(0,0,1,0, 4'd0,  4'd1,  2,2, 0, 8,0);
        vecs[11] = mkv(0,0,1,1, 4'd2,  4'd10, 2,1, 1, 8,0);
        vecs[12] = mkv(0,1,1,0, 4'd0,  4'd2,  2,1, 1, 8,1);
        vecs[13] = mkv(1,1,0,0, 4'd0,  4'd5,  2,0, 0, 8,0);
        vecs[14] = mkv(0,1,0,0, 4'd0,  4'd13, 3,0, 0,12,0);
        vecs[15] = mkv(0,0,1,0, 4'd0,  4'd13, 3,0, 0,12,1);
        vecs[16] = mkv(0,0,0,1, 4'd13, 4'd15, 3,1,-1, 0,0);
        vecs[17] = mkv(0,0,0,1, 4'd6,  4'd0,  3,2, 0, 0,0);
        vecs[18] = mkv(1,0,0,0, 4'd0,  4'd13, 3,0, 0,12,0);

        // ---- reset values while rst is low
        clear_cmd();
        bus.query_rank = 4'd1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset", 0, 0, 0, 0, 0);
        check("reset tc", bus.tc, 0);
        check("reset tc_valid", bus.tc_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- single-cycle command table
        for (int i = 0; i < 19; i++) begin
            bus.query_rank = vecs[i].qrank;
            step(vecs[i].ns, vecs[i].da, vecs[i].bk, vecs[i].cv, vecs[i].rank);
            check_state($sformatf("vec%0d", i), vecs[i].deck, vecs[i].total,
                        vecs[i].running, vecs[i].qleft, int'(vecs[i].err));
        end

        // ---- two decks, one 5; true count and restart mid-division
        do_reset();
        bus.query_rank = 4'd5;
        step(0,1,0,0,4'd0);
        step(0,1,0,0,4'd0);
        card(4'd5);
        check_state("two-deck", 2, 1, 1, 7, 0);
        measure_tc("two-deck", TC_EN ? 26 : 0, 0);
        card(4'd2);
        check("restart drops tc_valid", bus.tc_valid, 0);
        watch_no_valid("no tc_valid mid-division", 10);
        card(4'd3);
        check("restart running", bus.running, 3);
        measure_tc("restart", TC_EN ? 26 : 0, TC_EN ? 1 : 0);

        // ---- one deck, ace exhaustion, negative true count
        do_reset();
        bus.query_rank = 4'd1;
        step(0,1,0,0,4'd0);
        repeat (4) card(4'd1);
        check("ace x4 err", bus.err, 0);
        card(4'd1);
        check_state("fifth ace", 1, 4, -4, 0, 1);
        measure_tc("aces", TC_EN ? 25 : 0, TC_EN ? -4 : 0);

        // ---- reset during a division
        card(4'd13);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("mid-div reset total", bus.total, 0);
        check("mid-div reset running", bus.running, 0);
        check("mid-div reset deck", bus.deck, 0);
        check("mid-div reset tc_valid", bus.tc_valid, 0);
        check("mid-div reset tc", bus.tc, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        measure_tc("after reset", 0, 0);

        // ---- deal a whole deck: remain reaches 0
        do_reset();
        bus.query_rank = 4'd7;
        step(0,1,0,0,4'd0);
        for (int r = 1; r <= 13; r++) begin
            for (int k = 0; k < 4; k++) card(4'(r));
        end
        check_state("full deal", 1, 52, 0, 0, 0);
        measure_tc("empty shoe", TC_EN ? 2 : 0, 0);
        card(4'd7);
        check("card past empty err", bus.err, 1);
        check("card past empty total", bus.total, 52);

        // ---- deck limit
        do_reset();
        repeat (8) step(0,1,0,0,4'd0);
        check("eight decks", bus.deck, 8);
        check("eight decks err", bus.err, 0);
        step(0,1,0,0,4'd0);
        check("ninth deck err", bus.err, 1);
        check("ninth deck deck", bus.deck, 8);

        // ---- undo depth: 10 cards, 9 backs
        do_reset();
        bus.query_rank = 4'd2;
        step(0,1,0,0,4'd0);
        for (int i = 0; i < 10; i++) card(undo_cards[i]);
        check("ten cards total", bus.total, 10);
        check("ten cards running", bus.running, 3);
        for (int i = 0; i < 8; i++) begin
            step(0,0,1,0,4'd0);
            check($sformatf("undo%0d err", i + 1), bus.err, 0);
        end
        check_state("eight undos", 1, 2, 2, 3, 0);
        step(0,0,1,0,4'd0);
        check_state("ninth undo", 1, 2, 2, 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
